// File: rtl/fp_pack_round.sv
// FP32 result packer: normalizes an extended mantissa one bit per cycle, rounds to
// nearest-even and packs sign/exponent/fraction into an IEEE-754 single word.
module fp_pack_round #(
    parameter int MANT_W = 28,
    parameter int EXP_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_in,
    input  logic              zero_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result,
    output logic              overflow,
    output logic              underflow
);
    localparam int XW  = EXP_W + 1;
    localparam int HID = MANT_W - 2;
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_MAX  = XW'(255);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t                  state_reg, state_next;
    logic                    sign_reg, sign_next;
    logic signed [XW-1:0]    exp_reg, exp_next;
    logic [MANT_W-1:0]       mant_reg, mant_next;
    logic [31:0]             result_reg, result_next;
    logic                    overflow_reg, overflow_next;
    logic                    underflow_reg, underflow_next;

    // Round-to-nearest-even on the current mantissa; evaluated every cycle, used in ROUND.
    logic                    rnd_up;
    logic [HID-2:0]          rnd_sum;
    logic [HID-3:0]          rnd_mant;
    logic signed [XW-1:0]    rnd_exp;
    logic [MANT_W-1:0]       norm_mant;
    logic signed [XW-1:0]    norm_exp;

    always_comb begin
        rnd_up  = mant_reg[2] & (mant_reg[1] | mant_reg[0] | mant_reg[3]);
        rnd_sum = {1'b0, mant_reg[HID:3]} + {{(HID-2){1'b0}}, rnd_up};
        if (rnd_sum[HID-2]) begin
            rnd_mant = rnd_sum[HID-2:1];
            rnd_exp  = exp_reg + EXP_ONE;
        end else begin
            rnd_mant = rnd_sum[HID-3:0];
            rnd_exp  = exp_reg;
        end
        norm_mant = mant_reg << 1;
        norm_exp  = exp_reg - EXP_ONE;
    end

    always_comb begin
        state_next     = state_reg;
        sign_next      = sign_reg;
        exp_next       = exp_reg;
        mant_next      = mant_reg;
        result_next    = result_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sign_next      = sign_in;
                    exp_next       = {exp_in[EXP_W-1], exp_in};
                    mant_next      = mant_in;
                    overflow_next  = 1'b0;
                    underflow_next = 1'b0;
                    if (zero_in || (mant_in == '0)) begin
                        result_next = {sign_in, 31'b0};
                        state_next  = DONE;
                    end else if (mant_in[MANT_W-1]) begin
                        // Carry bit set: shift right, keeping the lost bit in sticky.
                        mant_next  = {1'b0, mant_in[MANT_W-1:2], mant_in[1] | mant_in[0]};
                        exp_next   = {exp_in[EXP_W-1], exp_in} + EXP_ONE;
                        state_next = ROUND;
                    end else if (mant_in[HID]) begin
                        state_next = ROUND;
                    end else begin
                        state_next = NORM;
                    end
                end
            end
            NORM: begin
                mant_next = norm_mant;
                exp_next  = norm_exp;
                if (norm_exp <= EXP_ZERO) begin
                    result_next    = {sign_reg, 31'b0};
                    underflow_next = 1'b1;
                    state_next     = DONE;
                end else if (norm_mant[HID]) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                if (rnd_exp >= EXP_MAX) begin
                    result_next   = {sign_reg, 8'hFF, 23'b0};
                    overflow_next = 1'b1;
                end else if (rnd_exp <= EXP_ZERO) begin
                    result_next    = {sign_reg, 31'b0};
                    underflow_next = 1'b1;
                end else begin
                    result_next = {sign_reg, rnd_exp[7:0], rnd_mant[22:0]};
                end
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sign_reg      <= 1'b0;
            exp_reg       <= '0;
            mant_reg      <= '0;
            result_reg    <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sign_reg      <= sign_next;
            exp_reg       <= exp_next;
            mant_reg      <= mant_next;
            result_reg    <= result_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_fp_pack_round.sv
// Vector-table bench for fp_pack_round with a scoreboard queue of expected results.
module tb_fp_pack_round;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [9:0]  exp_in;
    logic [27:0] mant_in;
    logic        zero_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [27:0] m;
        logic        z;
        logic [31:0] r;
        logic        ov;
        logic        un;
        int          lat;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];
    vec_t sb_q[$];

    always #5 clk = ~clk;

    fp_pack_round dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in), .zero_in(zero_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .underflow(underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        vec_t exp_v;
        int   lat;
        @(negedge clk);
        sign_in  = v.s;
        exp_in   = v.e;
        mant_in  = v.m;
        zero_in  = v.z;
        in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(v);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        exp_v = sb_q.pop_front();
        if (!out_valid) begin
            check($sformatf("v%0d timeout", idx), {31'b0, out_valid}, 32'd1);
        end else begin
            $display("vec %0d: s=%0d e=0x%03h m=0x%07h z=%0d -> result=0x%08h ov=%0d un=%0d lat=%0d",
                     idx, v.s, v.e, v.m, v.z, result, overflow, underflow, lat);
            check($sformatf("v%0d result", idx), result, exp_v.r);
            check($sformatf("v%0d overflow", idx), {31'b0, overflow}, {31'b0, exp_v.ov});
            check($sformatf("v%0d underflow", idx), {31'b0, underflow}, {31'b0, exp_v.un});
            check($sformatf("v%0d latency", idx), lat, exp_v.lat);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check($sformatf("v%0d release", idx), {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 10'd127, 28'h4000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 2};
        vecs[1]  = '{1'b0, 10'd127, 28'h8000000, 1'b0, 32'h40000000, 1'b0, 1'b0, 2};
        vecs[2]  = '{1'b0, 10'd130, 28'h0800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 5};
        vecs[3]  = '{1'b0, 10'd127, 28'h4000004, 1'b0, 32'h3F800000, 1'b0, 1'b0, 2};
        vecs[4]  = '{1'b0, 10'd127, 28'h400000C, 1'b0, 32'h3F800002, 1'b0, 1'b0, 2};
        vecs[5]  = '{1'b0, 10'd127, 28'h7FFFFFC, 1'b0, 32'h40000000, 1'b0, 1'b0, 2};
        vecs[6]  = '{1'b1, 10'd255, 28'h4000000, 1'b0, 32'hFF800000, 1'b1, 1'b0, 2};
        vecs[7]  = '{1'b0, 10'd2,   28'h1000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 3};
        vecs[8]  = '{1'b1, 10'd127, 28'h4000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 1};
        vecs[9]  = '{1'b0, 10'd127, 28'h0000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1};
        vecs[10] = '{1'b0, 10'd0,   28'h4000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 2};
        vecs[11] = '{1'b0, 10'd254, 28'h8000000, 1'b0, 32'h7F800000, 1'b1, 1'b0, 2};
        vecs[12] = '{1'b1, 10'd254, 28'h7FFFFFC, 1'b0, 32'hFF800000, 1'b1, 1'b0, 2};
        vecs[13] = '{1'b0, 10'd254, 28'h7FFFFF8, 1'b0, 32'h7F7FFFFF, 1'b0, 1'b0, 2};
        vecs[14] = '{1'b0, 10'd1,   28'h4000000, 1'b0, 32'h00800000, 1'b0, 1'b0, 2};
        vecs[15] = '{1'b0, 10'd2,   28'h2000000, 1'b0, 32'h00800000, 1'b0, 1'b0, 3};
        vecs[16] = '{1'b0, 10'd200, 28'h0000001, 1'b0, 32'h57000000, 1'b0, 1'b0, 28};
        vecs[17] = '{1'b1, 10'h3FB, 28'h4000000, 1'b0, 32'h80000000, 1'b0, 1'b1, 2};
        vecs[18] = '{1'b0, 10'd127, 28'h4000005, 1'b0, 32'h3F800001, 1'b0, 1'b0, 2};
        vecs[19] = '{1'b0, 10'd127, 28'h8000009, 1'b0, 32'h40000001, 1'b0, 1'b0, 2};

        rst = 1'b1; in_valid = 1'b0; sign_in = 1'b0; exp_in = '0; mant_in = '0;
        zero_in = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {30'b0, overflow, underflow}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Stall in DONE with a pending request: result must hold, nothing accepted.
        @(negedge clk);
        sign_in = 1'b0; exp_in = 10'd127; mant_in = 28'h4000000; zero_in = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        sign_in = 1'b1; exp_in = 10'd130; mant_in = 28'h8000000;
        for (int c = 0; c < 5 && !out_valid; c++) begin
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 3; c++) begin
            $display("stall cycle %0d: out_valid=%0d in_ready=%0d result=0x%08h",
                     c, out_valid, in_ready, result);
            check("stall result", result, 32'h3F800000);
            check("stall handshake", {30'b0, out_valid, in_ready}, 32'd2);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall release", {30'b0, out_valid, in_ready}, 32'd1);

        // Reset while normalizing: the op is dropped and nothing comes out.
        @(negedge clk);
        sign_in = 1'b0; exp_in = 10'd130; mant_in = 28'h0100000; zero_in = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("norm busy", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort in_ready", {31'b0, in_ready}, 32'd1);
        begin
            logic seen = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen = 1'b1;
            end
            $display("abort: out_valid seen=%0d result=0x%08h", seen, result);
            check("abort no output", {31'b0, seen}, 32'd0);
            check("abort result", result, 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
